// File: rtl/key_line_debouncer_4_if.sv
// ---------------------------------------------------------------------------
// key_line_debouncer_4_if
//
// Purpose : groups the key-line conditioning signals between the raw key
//           source (master) and the debouncer (slave).
//
// Signals :
//   raw_lines [3:0]  raw, asynchronous, active-high key/request lines
//   out_lines [3:0]  debounced lines; always 0000 or one-hot
//   key_valid        one-cycle strobe per accepted press
//   key_held         high while an accepted key is held (== |out_lines)
//   multi_err        one-cycle strobe when a stable multi-line pattern is
//                    rejected
//   dbg_state [1:0]  current debouncer state (0 IDLE, 1 DEBOUNCE, 2 HELD,
//                    3 RELEASE), for observation only
//
// Handshake: key_valid and multi_err are single-cycle strobes with no
// backpressure (there is no ready). A strobe is valid for exactly the cycle
// it is high. key_valid coincides with out_lines first showing the accepted
// one-hot code; out_lines then stays valid while key_held is high. The two
// strobes never assert in the same cycle.
// ---------------------------------------------------------------------------
interface key_line_debouncer_4_if;
    logic [3:0] raw_lines;
    logic [3:0] out_lines;
    logic       key_valid;
    logic       key_held;
    logic       multi_err;
    logic [1:0] dbg_state;

    // Key source / consumer side.
    modport master (
        output raw_lines,
        input  out_lines,
        input  key_valid,
        input  key_held,
        input  multi_err,
        input  dbg_state
    );

    // Debouncer side.
    modport slave (
        input  raw_lines,
        output out_lines,
        output key_valid,
        output key_held,
        output multi_err,
        output dbg_state
    );
endinterface

// File: rtl/key_line_debouncer_4.sv
// ---------------------------------------------------------------------------
// key_line_debouncer_4
//
// Purpose : upstream conditioning stage for the 4-to-2 encoder. Synchronises
//           four raw key lines, debounces them, rejects stable multi-line
//           activity and presents a clean zero-or-one-hot vector that can
//           drive the encoder's in_lines directly.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to accept
//                    a press (1 .. 2**CNT_W-1)
//   CNT_W            width of the stability counter
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous, active-high reset; overrides everything
//   bus   key_line_debouncer_4_if.slave (raw_lines in; out_lines, key_valid,
//         key_held, multi_err, dbg_state out)
//
// Timing summary (N = DEBOUNCE_CYCLES):
//   - raw lines stable before edge E0 are accepted at edge E0+N+2
//     (2 synchroniser edges, one IDLE->DEBOUNCE edge, N-1 counting edges,
//     one accept edge).
//   - a release before edge R0 clears out_lines at edge R0+2.
//   - after leaving HELD or rejecting a pattern, IDLE is re-entered only
//     after N+1 consecutive all-zero samples.
// ---------------------------------------------------------------------------
module key_line_debouncer_4 #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    key_line_debouncer_4_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Two-flop synchroniser; r_sync2 is the only copy the FSM looks at.
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;

    // Debounce bookkeeping.
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;

    // Registered outputs.
    logic [3:0]       r_out_lines;
    logic             r_key_valid;
    logic             r_key_held;
    logic             r_multi_err;

    // Candidate is exactly one-hot: nonzero and clearing its lowest set bit
    // leaves nothing.
    logic             w_cand_onehot;
    logic             w_sync_zero;
    logic             w_sync_eq_cand;
    logic             w_cnt_done;

    assign w_cand_onehot  = (r_cand != 4'd0) && ((r_cand & (r_cand - 4'd1)) == 4'd0);
    assign w_sync_zero    = (r_sync2 == 4'd0);
    assign w_sync_eq_cand = (r_sync2 == r_cand);
    assign w_cnt_done     = (r_cnt == N_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 4'd0;
            r_sync2     <= 4'd0;
            r_cand      <= 4'd0;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
            r_out_lines <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_sync1     <= bus.raw_lines;
            r_sync2     <= r_sync1;

            // Strobes default low so each event yields exactly one cycle.
            r_key_valid <= 1'b0;
            r_multi_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_out_lines <= 4'd0;
                    r_key_held  <= 1'b0;
                    if (!w_sync_zero) begin
                        r_cand  <= r_sync2;
                        r_cnt   <= CNT_ONE;
                        r_state <= ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_sync_zero) begin
                        r_state <= ST_IDLE;
                    end else if (!w_sync_eq_cand) begin
                        // Pattern moved: restart stability count on the new one.
                        r_cand <= r_sync2;
                        r_cnt  <= CNT_ONE;
                    end else if (w_cnt_done) begin
                        if (w_cand_onehot) begin
                            r_out_lines <= r_cand;
                            r_key_held  <= 1'b1;
                            r_key_valid <= 1'b1;
                            r_state     <= ST_HELD;
                        end else begin
                            // Stable multi-line pattern: lock out until all
                            // lines have been quiet long enough. The counter
                            // must restart so RELEASE sees a full N+1 zeros.
                            r_multi_err <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_HELD: begin
                    // Any change (release, other key, extra key) drops the
                    // output; a new key is only taken after a full release.
                    if (!w_sync_eq_cand) begin
                        r_out_lines <= 4'd0;
                        r_key_held  <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    r_out_lines <= 4'd0;
                    r_key_held  <= 1'b0;
                    if (!w_sync_zero) begin
                        r_cnt <= '0;
                    end else if (w_cnt_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_out_lines <= 4'd0;
                    r_key_held  <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_lines = r_out_lines;
    assign bus.key_valid = r_key_valid;
    assign bus.key_held  = r_key_held;
    assign bus.multi_err = r_multi_err;
    assign bus.dbg_state = r_state;

endmodule
